modulo_pc_pilha: RTL and testbench

//  Parametrised program counter with return-address stack, stall and halt/loop control.

---
 rtl/pc_pkg.sv | 18 +
 rtl/pilha_retorno.sv | 58 +++++
 rtl/modulo_pc_pilha.sv | 147 ++++++++++++++
 tb/tb_modulo_pc_pilha.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared encodings for the program counter: FSM states and next-PC source selector.
package pc_pkg;

  typedef enum logic [1:0] {
    S_INICIO = 2'd0,
    S_EXEC   = 2'd1,
    S_PARADO = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SRC_HOLD  = 3'd0,
    SRC_RESET = 3'd1,
    SRC_SEQ   = 3'd2,
    SRC_ALVO  = 3'd3,
    SRC_TOPO  = 3'd4
  } pc_src_e;

endpackage

// File: rtl/pilha_retorno.sv
// Return-address LIFO: push/pop/clear with occupancy count; full/empty are
// decoded from the count so the caller can decide what an illegal access means.
module pilha_retorno #(
  parameter int ADDR_WIDTH  = 13,
  parameter int STACK_DEPTH = 8,
  parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] din,
  output logic [ADDR_WIDTH-1:0] top,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      top_cnt;

  assign full    = (count_q == CNT_W'(STACK_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign top_cnt = empty ? '0 : (count_q - CNT_W'(1));
  assign top     = mem_q[top_cnt[IDX_W-1:0]];

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (push && !full) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage carries no reset; only the count decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full && !clear) begin
      mem_q[count_q[IDX_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/modulo_pc_pilha.sv
// Program counter with return-address stack, stall, and halt/loop control.
// Instrucao is the registered PC; next PC picks hold/reset/seq/target/stack-top.
module modulo_pc_pilha
  import pc_pkg::*;
#(
  parameter int ADDR_WIDTH  = 13,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_ADDR  = 0,
  parameter int INCR        = 1
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic                               PCFunct,
  input  logic                               jump,
  input  logic                               call,
  input  logic                               ret,
  input  logic [ADDR_WIDTH-1:0]              Alvo,
  input  logic                               halt,
  input  logic                               loop_enable,
  output logic [ADDR_WIDTH-1:0]              Instrucao,
  output logic                               program_finished,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
  output logic                               stack_overflow,
  output logic                               stack_underflow
);

  localparam int                    CNT_W  = $clog2(STACK_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_ADDR);
  localparam logic [ADDR_WIDTH-1:0] INC_PC = ADDR_WIDTH'(INCR);

  pc_state_e             state_q, state_d;
  pc_src_e               src;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_seq, stk_top;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  push, pop, clear, full, empty;
  logic [CNT_W-1:0]      cnt;

  // Wraps naturally at 2**ADDR_WIDTH; the same value is what a call pushes.
  assign pc_seq = pc_q + INC_PC;

  pilha_retorno #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STACK_DEPTH(STACK_DEPTH),
    .CNT_W      (CNT_W)
  ) u_pilha (
    .clk  (Clock),
    .rst  (Reset),
    .push (push),
    .pop  (pop),
    .clear(clear),
    .din  (pc_seq),
    .top  (stk_top),
    .count(cnt),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    state_d = state_q;
    src     = SRC_HOLD;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (PCFunct) begin
      if (halt && (state_q != S_PARADO)) begin
        if (loop_enable) begin
          src     = SRC_RESET;
          clear   = 1'b1;
          state_d = S_EXEC;
        end else begin
          state_d = S_PARADO;
        end
      end else begin
        unique case (state_q)
          S_INICIO: state_d = S_EXEC;
          S_EXEC: begin
            if (ret) begin
              if (!empty) begin
                src = SRC_TOPO;
                pop = 1'b1;
              end else begin
                src   = SRC_SEQ;
                unf_d = 1'b1;
              end
            end else if (call) begin
              src = SRC_ALVO;
              if (!full) begin
                push = 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end else if (jump) begin
              src = SRC_ALVO;
            end else begin
              src = SRC_SEQ;
            end
          end
          S_PARADO: begin
            if (halt && loop_enable) begin
              src     = SRC_RESET;
              clear   = 1'b1;
              state_d = S_EXEC;
            end
          end
          default: begin
            src     = SRC_RESET;
            state_d = S_INICIO;
          end
        endcase
      end
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (src)
      SRC_RESET: pc_d = RST_PC;
      SRC_SEQ:   pc_d = pc_seq;
      SRC_ALVO:  pc_d = Alvo;
      SRC_TOPO:  pc_d = stk_top;
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_INICIO;
      pc_q    <= RST_PC;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign Instrucao        = pc_q;
  assign program_finished = (state_q == S_PARADO);
  assign stack_count      = cnt;
  assign stack_overflow   = ovf_q;
  assign stack_underflow  = unf_q;

endmodule

// File: tb/tb_modulo_pc_pilha.sv
// Scoreboard bench for modulo_pc_pilha: directed steps queue hand-computed
// post-edge state; a monitor pops and compares after every rising edge.
module tb_modulo_pc_pilha;

  localparam int AW = 13;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, pcf, jmp, cal, rt, hlt, lpe;
  logic [AW-1:0] alvo;
  logic [AW-1:0] instr;
  logic          pf, ovf, unf;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  modulo_pc_pilha #(
    .ADDR_WIDTH (AW),
    .STACK_DEPTH(8),
    .RESET_ADDR (0),
    .INCR       (1)
  ) u_dut (
    .Clock           (clk),
    .Reset           (rst),
    .PCFunct         (pcf),
    .jump            (jmp),
    .call            (cal),
    .ret             (rt),
    .Alvo            (alvo),
    .halt            (hlt),
    .loop_enable     (lpe),
    .Instrucao       (instr),
    .program_finished(pf),
    .stack_count     (cnt),
    .stack_overflow  (ovf),
    .stack_underflow (unf)
  );

  typedef struct {
    string         nm;
    logic [AW-1:0] pc;
    logic [CW-1:0] cnt;
    logic          pf;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if (instr !== mon_e.pc || cnt !== mon_e.cnt || pf !== mon_e.pf ||
          ovf !== mon_e.ovf || unf !== mon_e.unf) begin
        n_err++;
        $display("FAIL %s: got pc=%0d cnt=%0d fin=%b ovf=%b unf=%b, want pc=%0d cnt=%0d fin=%b ovf=%b unf=%b",
                 mon_e.nm, instr, cnt, pf, ovf, unf,
                 mon_e.pc, mon_e.cnt, mon_e.pf, mon_e.ovf, mon_e.unf);
      end
    end
  end

  // Drive one cycle of stimulus and queue the state expected after the next edge.
  task automatic step(input string nm, input int r, input int p, input int j,
                      input int c, input int t, input int h, input int l,
                      input int a, input int epc, input int ec,
                      input int ef, input int eo, input int eu);
    exp_t e;
    @(negedge clk);
    rst  = (r != 0);
    pcf  = (p != 0);
    jmp  = (j != 0);
    cal  = (c != 0);
    rt   = (t != 0);
    hlt  = (h != 0);
    lpe  = (l != 0);
    alvo = AW'(a);
    e.nm  = nm;
    e.pc  = AW'(epc);
    e.cnt = CW'(ec);
    e.pf  = (ef != 0);
    e.ovf = (eo != 0);
    e.unf = (eu != 0);
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pcf = 1'b0; jmp = 1'b0; cal = 1'b0; rt = 1'b0;
    hlt = 1'b0; lpe = 1'b0; alvo = '0;

    //    name               r p j c t h l alvo   pc cnt pf ovf unf
    step("t1_reset",         1,1,0,0,0,0,0,   0,   0, 0, 0, 0, 0);
    step("t1_first_fetch",   0,1,0,0,0,0,0,   0,   0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      step("t1_seq",         0,1,0,0,0,0,0,   0,   i, 0, 0, 0, 0);

    step("t2_call",          0,1,0,1,0,0,0,  40,  40, 1, 0, 0, 0);
    step("t2_seq41",         0,1,0,0,0,0,0,   0,  41, 1, 0, 0, 0);
    step("t2_seq42",         0,1,0,0,0,0,0,   0,  42, 1, 0, 0, 0);
    step("t2_ret",           0,1,0,0,1,0,0,   0,   6, 0, 0, 0, 0);

    for (int i = 0; i < 9; i++)
      step("t3_call",        0,1,0,1,0,0,0, 100+10*i, 100+10*i,
           (i < 8) ? i+1 : 8, 0, (i == 8) ? 1 : 0, 0);
    for (int k = 0; k < 9; k++)
      step("t3_ret",         0,1,0,0,1,0,0,   0,
           (k < 7) ? 161-10*k : ((k == 7) ? 7 : 8),
           (k < 8) ? 7-k : 0, 0, 1, (k == 8) ? 1 : 0);
    step("t3_call_pre",      0,1,0,1,0,0,0, 300, 300, 1, 0, 1, 1);
    step("t3_call_and_ret",  0,1,0,1,1,0,0, 500,   9, 0, 0, 1, 1);
    step("t3_jump",          0,1,1,0,0,0,0,  20,  20, 0, 0, 1, 1);

    step("t4_halt_stop",     0,1,0,0,0,1,0,   0,  20, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++)
      step("t4_parado_hold", 0,1,1,1,1,0,0,  77,  20, 0, 1, 1, 1);
    step("t4_parado_halt",   0,1,0,0,0,1,0,   0,  20, 0, 1, 1, 1);
    step("t4_restart",       0,1,0,0,0,1,1,   0,   0, 0, 0, 1, 1);
    step("t4_exec",          0,1,0,0,0,0,0,   0,   1, 0, 0, 1, 1);
    step("t4_call",          0,1,0,1,0,0,0,  50,  50, 1, 0, 1, 1);
    step("t4_halt_loop",     0,1,0,0,0,1,1,   0,   0, 0, 0, 1, 1);
    step("t4_after_loop",    0,1,0,0,0,0,0,   0,   1, 0, 0, 1, 1);

    step("t5_jump_max",      0,1,1,0,0,0,0,8191,8191, 0, 0, 1, 1);
    step("t5_wrap",          0,1,0,0,0,0,0,   0,   0, 0, 0, 1, 1);
    step("t5_stall_jump",    0,0,1,0,0,0,0,  99,   0, 0, 0, 1, 1);
    step("t5_stall_call",    0,0,0,1,0,0,0,  99,   0, 0, 0, 1, 1);
    step("t5_stall_halt",    0,0,0,0,0,1,0,   0,   0, 0, 0, 1, 1);
    step("t5_resume",        0,1,0,0,0,0,0,   0,   1, 0, 0, 1, 1);
    step("t5_jump_max2",     0,1,1,0,0,0,0,8191,8191, 0, 0, 1, 1);
    step("t5_call_wrap",     0,1,0,1,0,0,0,  30,  30, 1, 0, 1, 1);
    step("t5_ret_wrap",      0,1,0,0,1,0,0,   0,   0, 0, 0, 1, 1);

    step("t6_call10",        0,1,0,1,0,0,0,  10,  10, 1, 0, 1, 1);
    step("t6_call20",        0,1,0,1,0,0,0,  20,  20, 2, 0, 1, 1);
    step("t6_call30",        0,1,0,1,0,0,0,  30,  30, 3, 0, 1, 1);
    step("t6_reset_call",    1,1,0,1,0,0,0,  60,   0, 0, 0, 0, 0);
    step("t6_stall_a",       0,0,0,0,0,0,0,   0,   0, 0, 0, 0, 0);
    step("t6_stall_b",       0,0,0,0,0,0,0,   0,   0, 0, 0, 0, 0);
    step("t6_first_fetch",   0,1,0,0,0,0,0,   0,   0, 0, 0, 0, 0);
    step("t6_seq",           0,1,0,0,0,0,0,   0,   1, 0, 0, 0, 0);
    step("t6_reset2",        1,1,0,0,0,0,0,   0,   0, 0, 0, 0, 0);
    step("t6_inicio_halt",   0,1,0,0,0,1,0,   0,   0, 0, 1, 0, 0);
    step("t6_restart",       0,1,0,0,0,1,1,   0,   0, 0, 0, 0, 0);
    step("t6_exec",          0,1,0,0,0,0,0,   0,   1, 0, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
